// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: S-box, GF(2^8) doubling, round count, FSM states.
package aes_pkg;

  localparam logic [3:0] NR = 4'd10;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    WAIT_KEY = 3'd2,
    ARK      = 3'd3,
    XFORM    = 3'd4,
    OUT      = 3'd5
  } state_t;

  localparam logic [7:0] SBOX_TABLE [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_round_xform.sv
// Combinational SubBytes + ShiftRows + MixColumns; last_round skips MixColumns.
module aes_round_xform
  import aes_pkg::*;
(
  input  logic [127:0] st_in,
  input  logic         last_round,
  output logic [127:0] st_out
);

  // sr[r][c]: byte at row r, column c after SubBytes and ShiftRows
  logic [7:0] sr [4][4];

  function automatic logic [31:0] mix_col(input logic [7:0] a0, input logic [7:0] a1,
                                          input logic [7:0] a2, input logic [7:0] a3);
    logic [7:0] m0, m1, m2, m3;
    m0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    m1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    m2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    m3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {m0, m1, m2, m3};
  endfunction

  // Substitute every byte; row r takes its byte from column (c + r) mod 4
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[r][c] = sbox(st_in[127 - 8*(4*((c + r) % 4) + r) -: 8]);
      end
    end
  end

  // Mix each column, or pass it through unchanged in the final round
  always_comb begin
    st_out = '0;
    for (int c = 0; c < 4; c++) begin
      if (last_round) begin
        st_out[127 - 32*c -: 32] = {sr[0][c], sr[1][c], sr[2][c], sr[3][c]};
      end else begin
        st_out[127 - 32*c -: 32] = mix_col(sr[0][c], sr[1][c], sr[2][c], sr[3][c]);
      end
    end
  end

endmodule

// File: rtl/aes_round_engine.sv
// Iterative AES-128 encryptor: 4-word load, word-serial AddRoundKey with
// round keys read from key_expand, one-cycle round transform, 4-word output.
// start is a single-cycle pulse accepted in any state; it always (re)starts
// LOAD at word 0 and the following four cycles carry plaintext on data_in.
module aes_round_engine
  import aes_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] data_in,
  input  logic        key_ready,
  input  logic [31:0] round_key,
  output logic [3:0]  round_key_num,
  output logic [1:0]  r_index,
  output logic [31:0] data_out,
  output logic        out_valid,
  output logic        busy,
  output logic        done,
  output state_t      fsm_state
);

  state_t       state, state_nx;
  logic [127:0] st;
  logic [127:0] xform_out;
  logic [3:0]   round_ctr;
  logic [1:0]   word_ctr;
  logic [6:0]   word_base;

  // Word 0 lives in bits [127:96], so the base bit index is 32 * (3 - word_ctr)
  assign word_base = {~word_ctr, 5'd0};
  assign fsm_state = state;

  aes_round_xform u_xform (
    .st_in      (st),
    .last_round (round_ctr == NR - 4'd1),
    .st_out     (xform_out)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state decode; start overrides every state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (start) state_nx = LOAD;
      LOAD:     if (word_ctr == 2'd3) state_nx = WAIT_KEY;
      WAIT_KEY: if (key_ready) state_nx = ARK;
      ARK:      if (word_ctr == 2'd3) state_nx = (round_ctr == NR) ? OUT : XFORM;
      XFORM:    state_nx = ARK;
      OUT:      if (word_ctr == 2'd3) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
    if (start) state_nx = LOAD;
  end

  // Datapath: plaintext capture, AddRoundKey, round transform, counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st        <= '0;
      round_ctr <= '0;
      word_ctr  <= '0;
    end else if (start) begin
      round_ctr <= '0;
      word_ctr  <= '0;
    end else begin
      case (state)
        LOAD: begin
          st[word_base +: 32] <= data_in;
          word_ctr            <= word_ctr + 2'd1;
          round_ctr           <= '0;
        end
        WAIT_KEY: word_ctr <= '0;
        ARK: begin
          st[word_base +: 32] <= st[word_base +: 32] ^ round_key;
          word_ctr            <= word_ctr + 2'd1;
        end
        XFORM: begin
          st        <= xform_out;
          round_ctr <= round_ctr + 4'd1;
        end
        OUT:     word_ctr <= word_ctr + 2'd1;
        default: word_ctr <= '0;
      endcase
    end
  end

  // Output decode: key read address only during ARK, ciphertext only during OUT
  always_comb begin
    round_key_num = (state == ARK) ? round_ctr : 4'd0;
    r_index       = (state == ARK) ? word_ctr : 2'd0;
    out_valid     = (state == OUT);
    data_out      = out_valid ? st[word_base +: 32] : 32'd0;
    done          = out_valid && (word_ctr == 2'd3);
    busy          = (state != IDLE);
  end

endmodule

// File: tb/tb_aes_round_engine.sv
// Bench for aes_round_engine: FIPS-197 vectors, key stall, back-to-back,
// abort and mid-run reset, with a queue-based output scoreboard.
module tb_aes_round_engine;
  import aes_pkg::*;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] data_in;
  logic        key_ready;
  logic [31:0] round_key;
  logic [3:0]  round_key_num;
  logic [1:0]  r_index;
  logic [31:0] data_out;
  logic        out_valid;
  logic        busy;
  logic        done;
  state_t      fsm_state;

  logic [31:0] rk_w [44];
  logic [7:0]  rcon [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  logic [31:0] exp_q[$];
  int          exp_done_q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          word_cnt = 0;
  int          fetch_idx = 0;

  aes_round_engine dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .data_in       (data_in),
    .key_ready     (key_ready),
    .round_key     (round_key),
    .round_key_num (round_key_num),
    .r_index       (r_index),
    .data_out      (data_out),
    .out_valid     (out_valid),
    .busy          (busy),
    .done          (done),
    .fsm_state     (fsm_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- key_expand stub ----------------
  always_comb begin
    round_key = 32'd0;
    if (round_key_num <= 4'd10) round_key = rk_w[int'(round_key_num) * 4 + int'(r_index)];
  end

  task automatic load_key(input logic [127:0] k);
    logic [31:0] t;
    for (int i = 0; i < 4; i++) rk_w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = rk_w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
        t = t ^ {rcon[i/4 - 1], 24'd0};
      end
      rk_w[i] = rk_w[i-4] ^ t;
    end
  endtask

  // ---------------- checking helper ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Start pulse in the next cycle, then four plaintext words; returns in the
  // cycle of the last word. lat < 0 means no output is expected for this block.
  task automatic send_block(input logic [127:0] pt, input logic [127:0] ct, input int lat);
    @(posedge clk); #1;
    start = 1'b1;
    data_in = '0;
    if (lat >= 0) begin
      for (int i = 0; i < 4; i++) exp_q.push_back(ct[127 - 32*i -: 32]);
      exp_done_q.push_back(cyc + lat);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      data_in = pt[127 - 32*i -: 32];
    end
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt < target) check("done_timeout", 128'(done_cnt), 128'(target));
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (reset) begin
      word_cnt = 0;
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) check("unexpected_out", 128'(data_out), 128'd0);
        else check("data_out", 128'(data_out), 128'(exp_q.pop_front()));
        check("done_pos", 128'(done), 128'(word_cnt == 3));
        if (done) begin
          done_cnt++;
          if (exp_done_q.size() == 0) check("unexpected_done", 128'(cyc), 128'd0);
          else check("done_cycle", 128'(cyc), 128'(exp_done_q.pop_front()));
          check("fetch_total", 128'(fetch_idx), 128'd44);
        end
        word_cnt = (word_cnt + 1) % 4;
      end else if (done) begin
        check("done_without_valid", 128'(done), 128'd0);
      end
      case (fsm_state)
        LOAD: fetch_idx = 0;
        ARK: begin
          check("fetch_seq", 128'({round_key_num, r_index}),
                128'({4'(fetch_idx / 4), 2'(fetch_idx % 4)}));
          fetch_idx++;
        end
        WAIT_KEY: begin
          check("wait_busy", 128'(busy), 128'd1);
          check("wait_key_num", 128'(round_key_num), 128'd0);
        end
        IDLE: check("idle_busy", 128'(busy), 128'd0);
        default: ;
      endcase
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_data_out"}, 128'(data_out), 128'd0);
    check({tag, "_out_valid"}, 128'(out_valid), 128'd0);
    check({tag, "_busy"}, 128'(busy), 128'd0);
    check({tag, "_done"}, 128'(done), 128'd0);
    check({tag, "_key_num"}, 128'(round_key_num), 128'd0);
    check({tag, "_r_index"}, 128'(r_index), 128'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    start = 1'b0;
    data_in = '0;
    key_ready = 1'b1;
    load_key(KEY_B);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // App. B vector, key already available
    send_block(PT_B, CT_B, 63);
    wait_done(1, 200);

    // App. C.1 vector
    load_key(KEY_C);
    send_block(PT_C, CT_C, 63);
    wait_done(2, 200);

    // Keys unavailable for 20 cycles after load
    load_key(KEY_B);
    key_ready = 1'b0;
    send_block(PT_B, CT_B, 83);
    repeat (21) @(posedge clk);
    #1 key_ready = 1'b1;
    wait_done(3, 200);

    // Back-to-back: second start in the done cycle of the first block
    send_block(PT_B, CT_B, 63);
    repeat (58) @(posedge clk);
    #1 load_key(KEY_C);
    send_block(PT_C, CT_C, 63);
    wait_done(5, 300);

    // Abort in round 5 with a new block
    load_key(KEY_B);
    send_block(PT_B, CT_B, -1);
    repeat (27) @(posedge clk);
    #1 load_key(KEY_C);
    send_block(PT_C, CT_C, 63);
    wait_done(6, 200);

    // Reset during ARK of round 3, then a clean App. B run
    load_key(KEY_B);
    send_block(PT_B, CT_B, -1);
    repeat (17) @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check_outputs_zero("midreset");
    exp_q.delete();
    exp_done_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    send_block(PT_B, CT_B, 63);
    wait_done(7, 200);

    repeat (5) @(posedge clk);
    check("done_count", 128'(done_cnt), 128'd7);
    check("queue_left", 128'(exp_q.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/aes_round_engine.md
# aes_round_engine

Iterative AES-128 encryption datapath that sits directly downstream of `key_expand`. It accepts a 128-bit plaintext as four 32-bit words, then runs the initial AddRoundKey, rounds 1-9 and final round 10. Round keys are fetched one word per cycle from `key_expand` through its `round_key_num`/`r_index` read port. The ciphertext is streamed out as four 32-bit words.

## Interface
No parameters; AES-128 only, with Nr = 10 fixed.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `start` in 1: one-cycle pulse; the next 4 cycles carry plaintext on `data_in`.
- `data_in` in 32: plaintext word; first word = bits [127:96].
- `key_ready` in 1: level, driven by `key_expand` `done`; round keys valid while high.
- `round_key` in 32: word from `key_expand`, combinational response to `round_key_num`/`r_index`.
- `round_key_num` out 4: round key index 0-10 requested.
- `r_index` out 2: word index 0-3 within the round key (0 = bits [127:96]).
- `data_out` out 32: ciphertext word, valid when `out_valid` is high.
- `out_valid` out 1: high for exactly 4 consecutive cycles per block.
- `busy` out 1: high from the cycle after `start` until the last output word.
- `done` out 1: one-cycle pulse coincident with the 4th output word.

## Operation
- State register `st[127:0]`; `round_ctr` 4 bits, range 0-10; `word_ctr` 2 bits.
- FSM states: IDLE, LOAD, WAIT_KEY, ARK, XFORM, OUT.
- IDLE: on `start`, go to LOAD with `word_ctr` = 0.
- LOAD: capture `data_in` into `st[127-32*word_ctr -: 32]`. After word 3, go to WAIT_KEY with `round_ctr` = 0.
- WAIT_KEY: hold until `key_ready` = 1, then go to ARK with `word_ctr` = 0.
  - `key_ready` is sampled only in this state.
  - Upstream must not restart key loading while `busy` is high; the engine does not check for this.
- ARK: drive `round_key_num` = `round_ctr` and `r_index` = `word_ctr`. XOR `round_key` into `st` word `word_ctr` at the clock edge. After word 3:
  - `round_ctr` = 10: go to OUT.
  - Otherwise: go to XFORM.
- XFORM, one cycle:
  - `st` <= MixColumns(ShiftRows(SubBytes(st))), with MixColumns omitted when `round_ctr` + 1 = 10.
  - `round_ctr` increments; return to ARK.
- OUT: `data_out` = `st` word `word_ctr` (MSB word first), `out_valid` = 1. `done` = 1 when `word_ctr` = 3, then go to IDLE.
- Arithmetic:
  - GF(2^8) multiply by 2 is `xtime(b)` = {b[6:0],1'b0} ^ (b[7] ? 8'h1b : 8'h00).
  - Column layout: byte `st[127:120]` = s(0,0), `st[119:112]` = s(1,0), and so on, column-major per FIPS-197.
- `start` in any non-IDLE state aborts the current block with no `done` and restarts LOAD from word 0.
- `start` asserted in the same cycle as the last OUT word: that word and `done` are still emitted, then LOAD begins.

## Timing
- Reset values:
  - `data_out` = 0, `out_valid` = 0, `busy` = 0, `done` = 0.
  - `round_key_num` = 0, `r_index` = 0.
  - FSM = IDLE; `st`, `round_ctr` and `word_ctr` = 0.
- Reset mid-operation returns to IDLE immediately; any partial block is discarded.
- Cycle counts, with `start` in cycle 0:
  - LOAD occupies cycles 1-4.
  - With `key_ready` already high: WAIT_KEY takes 1 cycle (cycle 5), ARK/XFORM take 11×4 + 10 = 54 cycles (cycles 6-59), OUT takes cycles 60-63.
  - `done` fires in cycle 63; start-to-done latency = 63 cycles.
- Next `start` is accepted in cycle 63 or later.
- `round_key_num`/`r_index` are combinational decodes of FSM/counters, so the round key arrives in the same cycle; there are no pipeline bubbles.

## Structure
- Shared package `aes_pkg` holds:
  - `sbox(byte)` function with the full 256-entry FIPS-197 table, reused by `key_expand`.
  - `xtime` function.
  - `NR` = 10.
  - `state_t` enum.
- One sub-module, `aes_round_xform`: combinational 128-bit SubBytes + ShiftRows + MixColumns with a `last_round` input that bypasses MixColumns.
- The top level holds the FSM, counters, the `st` register and the AddRoundKey XOR.

## Test plan
The bench stubs `round_key` from a model of FIPS-197 expanded keys.
- FIPS-197 App. B:
  - Stimulus: key 2b7e1516 28aed2a6 abf71588 09cf4f3c; plaintext 3243f6a8 885a308d 313198a2 e0370734.
  - Required: outputs 3925841d 02dc09fb dc118597 196a0b32, with `done` in cycle 63.
- FIPS-197 App. C.1:
  - Stimulus: key 00010203…0c0d0e0f; plaintext 00112233 44556677 8899aabb ccddeeff.
  - Required: outputs 69c4e0d8 6a7b0430 d8cdb780 70b4c55a.
- `key_ready` held low for 20 cycles after load:
  - Required: engine stays in WAIT_KEY with `busy` = 1 and no `round_key_num` change; correct ciphertext follows, `done` delayed by exactly 20 cycles.
- Fetch sequence:
  - Required: monitor `round_key_num`/`r_index` during ARK and check the order (0,0..3), (1,0..3) … (10,0..3), with no repeats or skips.
- Abort: `start` pulsed in round 5 with new plaintext (App. C.1 vector):
  - Required: no `done` for the aborted block; the App. C.1 ciphertext is produced 63 cycles after the second `start`.
- Reset during ARK of round 3:
  - Required: all outputs read 0 in the next cycle; a subsequent App. B run produces the correct result.
